// File: rtl/servisia_pkg.sv
// Shared definitions for the SERV SoC boot loader.
//   state_t    : loader FSM state encoding
//   WB_SEL_ALL : Wishbone byte-select value for full 32-bit accesses
package servisia_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/servisia_wb_loader.sv
// Boot-time Wishbone initiator: assembles a little-endian byte stream into
// 32-bit words, writes each word to RAM (optionally reading it back to
// verify) and releases the core reset once the whole image is in place.
//
// Ports
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   byte_i/byte_valid_i/ready_o : boot byte stream (transfer on valid & ready)
//   wb_adr_o .. wb_stb_o        : Wishbone initiator outputs
//   wb_dat_i, wb_ack_i          : Wishbone responder inputs
//   cpu_rst_o                   : core reset, held until the image is loaded
//   done_o / err_o              : sticky completion / failure flags
module servisia_wb_loader
    import servisia_pkg::*;
#(
    parameter int unsigned ADR_WIDTH   = 16,
    parameter int unsigned BASE_ADR    = 0,
    parameter int unsigned IMAGE_WORDS = 256,
    parameter int unsigned TIMEOUT     = 15,
    parameter int unsigned VERIFY      = 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [7:0]           byte_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    output logic [ADR_WIDTH-1:0] wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    output logic                 wb_we_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i,
    output logic                 cpu_rst_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int unsigned IDX_W = $clog2(IMAGE_WORDS + 1);
    // The timeout counter only needs to reach TIMEOUT-1.
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IMAGE_WORDS - 1);

    state_t             state;
    logic [1:0]         byte_cnt;
    logic [23:0]        low_bytes;
    logic [IDX_W-1:0]   word_idx;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               last_word;
    logic               tmo_hit;

    assign last_word = (word_idx == IDX_LAST);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    // Byte address of a word, wrapping modulo 2^ADR_WIDTH.
    function automatic logic [ADR_WIDTH-1:0] word_adr(input logic [IDX_W-1:0] idx);
        return ADR_WIDTH'(BASE_ADR) + ADR_WIDTH'({idx, 2'b00});
    endfunction

    // Loader FSM with registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= ST_COLLECT;
            byte_cnt     <= '0;
            low_bytes    <= '0;
            word_idx     <= '0;
            tmo_cnt      <= '0;
            byte_ready_o <= 1'b0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            wb_we_o      <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            cpu_rst_o    <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    byte_ready_o <= 1'b1;
                    if (byte_valid_i && byte_ready_o) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        // Shift in from the top so the first byte ends up lowest.
                        low_bytes <= {byte_i, low_bytes[23:8]};
                        if (byte_cnt == 2'd3) begin
                            state        <= ST_WRITE;
                            byte_ready_o <= 1'b0;
                            wb_adr_o     <= word_adr(word_idx);
                            wb_dat_o     <= {byte_i, low_bytes};
                            wb_sel_o     <= WB_SEL_ALL;
                            wb_we_o      <= 1'b1;
                            wb_cyc_o     <= 1'b1;
                            wb_stb_o     <= 1'b1;
                            tmo_cnt      <= '0;
                        end
                    end
                end

                ST_WRITE: begin
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                        if (VERIFY != 0) begin
                            state <= ST_READ;
                        end else begin
                            word_idx <= word_idx + IDX_W'(1);
                            if (last_word) begin
                                state     <= ST_DONE;
                                done_o    <= 1'b1;
                                cpu_rst_o <= 1'b0;
                            end else begin
                                state        <= ST_COLLECT;
                                byte_ready_o <= 1'b1;
                            end
                        end
                    end else if (tmo_hit) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                        state    <= ST_ERROR;
                        err_o    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                // First cycle in READ is the mandatory idle gap; stb rises after it.
                ST_READ: begin
                    if (!wb_stb_o) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= WB_SEL_ALL;
                        tmo_cnt  <= '0;
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= '0;
                        if (wb_dat_i != wb_dat_o) begin
                            state <= ST_ERROR;
                            err_o <= 1'b1;
                        end else begin
                            word_idx <= word_idx + IDX_W'(1);
                            if (last_word) begin
                                state     <= ST_DONE;
                                done_o    <= 1'b1;
                                cpu_rst_o <= 1'b0;
                            end else begin
                                state        <= ST_COLLECT;
                                byte_ready_o <= 1'b1;
                            end
                        end
                    end else if (tmo_hit) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= '0;
                        state    <= ST_ERROR;
                        err_o    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                ST_DONE: begin
                end

                ST_ERROR: begin
                end

                default: begin
                    state        <= ST_ERROR;
                    err_o        <= 1'b1;
                    byte_ready_o <= 1'b0;
                    wb_cyc_o     <= 1'b0;
                    wb_stb_o     <= 1'b0;
                    wb_we_o      <= 1'b0;
                    wb_sel_o     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servisia_wb_loader.sv
// Bench for servisia_wb_loader: two instances (write-only and verify mode,
// two-word image, timeout 15) each driven by a byte source, a Wishbone
// responder with configurable ack latency, and a transaction-level model.
module tb_servisia_wb_loader;

    localparam int unsigned TMO_CYCLES = 15;

    typedef struct packed {
        logic [15:0] adr;
        logic        we;
        logic [31:0] dat;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        rst = 1'b1;
        logic [7:0]  byte_d = 8'h00;
        logic        byte_valid = 1'b0;
        logic        byte_ready;
        logic [15:0] adr;
        logic [31:0] dat_o;
        logic [3:0]  sel;
        logic        we, cyc, stb;
        logic [31:0] dat_i = 32'h0;
        logic        ack = 1'b0;
        logic        cpu_rst, done, err;

        servisia_wb_loader #(
            .ADR_WIDTH(16), .BASE_ADR(0), .IMAGE_WORDS(2), .TIMEOUT(15), .VERIFY(g)
        ) u_dut (
            .wb_clk_i(clk), .wb_rst_i(rst),
            .byte_i(byte_d), .byte_valid_i(byte_valid), .byte_ready_o(byte_ready),
            .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_we_o(we),
            .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_dat_i(dat_i), .wb_ack_i(ack),
            .cpu_rst_o(cpu_rst), .done_o(done), .err_o(err)
        );

        logic [7:0]  src_q[$];
        txn_t        exp_q[$];
        logic [15:0] wr_adr_log[$];
        logic [31:0] mem[2];
        int          ack_delay = 1;
        int          rsp_cnt = 0;
        int          consumed = 0;
        int          tmo_seen = 0;
        int          stb_cnt = 0;
        bit          spur = 0, spur_tog = 0, bad0 = 0, feed = 0;
        bit          prev_cyc = 0, seen_done = 0, seen_err = 0, fin = 0;
        logic        fire_r = 1'b0;
        logic        last_we = 1'b0;
        logic [15:0] last_adr = '0;
        logic [31:0] last_dat = '0;

        function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
            check($sformatf("g%0d_%s", g, nm), a, e);
        endfunction

        always @(posedge clk) fire_r <= byte_valid & byte_ready & ~rst;

        // Byte source and Wishbone responder, both updated away from the active edge.
        always @(negedge clk) begin
            if (fire_r && src_q.size() > 0) begin
                void'(src_q.pop_front());
                consumed++;
            end
            byte_valid = feed && (src_q.size() > 0);
            if (byte_valid) byte_d = src_q[0];
            else            byte_d = 8'h00;

            if (!stb) begin
                rsp_cnt  = 0;
                spur_tog = !spur_tog;
                ack      = spur && spur_tog;
            end else begin
                rsp_cnt++;
                ack = (ack_delay > 0) && (rsp_cnt == ack_delay);
                if (ack && !we)
                    dat_i = (bad0 && adr == 16'h0) ? 32'hDEADBEEF : mem[adr[2]];
            end
        end

        // Per-cycle comparison against the transaction model and output rules.
        always @(posedge clk) begin
            txn_t t;
            #1;
            if (rst) begin
                chk("reset_ctrl", 32'({cyc, stb, we, byte_ready, done, err, cpu_rst, sel}), 32'h010);
                chk("reset_bus", 32'(adr) | dat_o, 32'h0);
                prev_cyc  = 0;
                stb_cnt   = 0;
                seen_done = 0;
                seen_err  = 0;
            end else begin
                chk("stb_eq_cyc", 32'(stb), 32'(cyc));
                chk("cpu_rst_vs_done", 32'(cpu_rst), 32'(!done));
                chk("ready_while_busy", 32'(byte_ready & cyc), 32'h0);
                if (cyc) chk("sel_all", 32'(sel), 32'hF);
                if (seen_done || seen_err)
                    chk("sticky", 32'({done, err, cyc, byte_ready}), 32'({seen_done, seen_err, 2'b00}));
                if (cyc && !prev_cyc) begin
                    stb_cnt = 1;
                    if (we) wr_adr_log.push_back(adr);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL g%0d_unexpected_cycle: got cycle adr=0x%04h we=%0b, required no cycle", g, adr, we);
                    end else begin
                        t = exp_q.pop_front();
                        chk("txn_adr", 32'(adr), 32'(t.adr));
                        chk("txn_we", 32'(we), 32'(t.we));
                        if (t.we) chk("txn_dat", dat_o, t.dat);
                    end
                end else if (cyc) begin
                    stb_cnt++;
                end
                if (!cyc && prev_cyc) begin
                    if (ack) begin
                        if (last_we) mem[last_adr[2]] = last_dat;
                    end else begin
                        tmo_seen++;
                        chk("stb_high_cycles", 32'(stb_cnt), 32'(TMO_CYCLES));
                    end
                end
                if (done) seen_done = 1;
                if (err)  seen_err  = 1;
                prev_cyc = cyc;
                if (cyc) begin
                    last_we  = we;
                    last_adr = adr;
                    last_dat = dat_o;
                end
            end
        end

        task automatic tick();
            @(posedge clk);
            #2;
        endtask

        // Queue the byte stream and derive the expected bus transactions from it.
        task automatic load_image(input logic [63:0] s, input int n, input bit bad);
            src_q.delete();
            exp_q.delete();
            wr_adr_log.delete();
            consumed = 0;
            for (int k = 0; k < n; k++) src_q.push_back(s[8*k +: 8]);
            for (int w = 0; w < n / 4; w++) begin
                logic [31:0] word;
                word = s[32*w +: 32];
                exp_q.push_back({16'(4 * w), 1'b1, word});
                if (g == 1) exp_q.push_back({16'(4 * w), 1'b0, word});
                if (bad) break;
            end
        endtask

        task automatic start(input logic [63:0] s, input int n, input int delay, input bit sp, input bit bad);
            rst  = 1'b1;
            feed = 0;
            tick();
            tick();
            mem[0]    = 32'h0;
            mem[1]    = 32'h0;
            tmo_seen  = 0;
            ack_delay = delay;
            spur      = sp;
            bad0      = bad;
            load_image(s, n, bad);
            rst  = 1'b0;
            feed = 1;
        endtask

        task automatic finish_chk(input string nm, input bit e_done, input bit e_err, input int e_bytes);
            bit hit = 0;
            for (int c = 0; c < 3000 && !hit; c++) begin
                tick();
                hit = done || err;
            end
            chk({nm, "_end_reached"}, 32'(hit), 32'h1);
            repeat (20) tick();
            chk({nm, "_done"}, 32'(done), 32'(e_done));
            chk({nm, "_err"}, 32'(err), 32'(e_err));
            chk({nm, "_cpu_rst"}, 32'(cpu_rst), 32'(!e_done));
            chk({nm, "_txn_left"}, 32'(exp_q.size()), 32'h0);
            chk({nm, "_bytes"}, 32'(consumed), 32'(e_bytes));
        endtask

        initial begin
            if (g == 0) begin
                start(64'h8877665544332211, 8, 1, 0, 0);
                finish_chk("basic", 1, 0, 8);
                chk("basic_mem0", mem[0], 32'h44332211);
                chk("basic_mem1", mem[1], 32'h88776655);
                chk("basic_nwr", 32'(wr_adr_log.size()), 32'd2);
                if (wr_adr_log.size() == 2) begin
                    chk("basic_adr0", 32'(wr_adr_log[0]), 32'h0);
                    chk("basic_adr1", 32'(wr_adr_log[1]), 32'h4);
                end

                start(64'h00000000DDCCBBAA, 4, 0, 0, 0);
                finish_chk("timeout", 0, 1, 4);
                chk("timeout_count", 32'(tmo_seen), 32'd1);

                start(64'h0807060504030201, 8, 5, 0, 0);
                finish_chk("stall", 1, 0, 8);
                chk("stall_mem0", mem[0], 32'h04030201);
                chk("stall_mem1", mem[1], 32'h08070605);
            end else begin
                start(64'hF0E1D2C3B4A59687, 8, 1, 1, 0);
                finish_chk("verify", 1, 0, 8);
                chk("verify_mem1", mem[1], 32'hF0E1D2C3);

                start(64'h8877665544332211, 8, 1, 0, 1);
                finish_chk("badread", 0, 1, 4);

                begin
                    bit seen = 0;
                    start(64'h8877665544332211, 8, 5, 0, 0);
                    for (int c = 0; c < 200 && !seen; c++) begin
                        tick();
                        seen = cyc && (stb_cnt >= 2);
                    end
                    chk("rst_mid_write_reached", 32'(seen), 32'h1);
                    rst = 1'b1;
                    tick();
                    chk("rst_bus_drop", 32'({cyc, stb, we}), 32'h0);
                    chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
                    chk("rst_no_write", mem[0], 32'h0);
                    ack_delay = 1;
                    load_image(64'h8877665544332211, 8, 0);
                    rst = 1'b0;
                    finish_chk("reload", 1, 0, 8);
                    chk("reload_mem0", mem[0], 32'h44332211);
                end
            end
            fin = 1;
        end
    end

    initial begin
        bit both = 0;
        for (int c = 0; c < 50000 && !both; c++) begin
            @(posedge clk);
            both = g_dut[0].fin && g_dut[1].fin;
        end
        if (!both) begin
            vectors++;
            miscompares++;
            $display("FAIL run_complete: got unfinished scenarios, required all finished");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
